// File: rtl/apb4_requester.sv
// apb4_requester: single-outstanding APB4 requester bridging a valid/ready
// command channel onto NUM_PERIPH completers (16-byte window each) and
// returning read data / error status on a valid/ready response channel.
// Optional ACCESS-phase timeout is built when APB4_REQ_TIMEOUT_EN is defined.
module apb4_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PERIPH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [2:0]                       PPROT,
  output logic [NUM_PERIPH-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_PERIPH-1:0]            PREADY,
  input  logic [NUM_PERIPH-1:0]            PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = ADDR_WIDTH - 4;
  localparam logic [IDX_WIDTH-1:0] NUM_PERIPH_IDX = IDX_WIDTH'(NUM_PERIPH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_d;
  logic                    cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d, pwdata_d, rdata_sel;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [2:0]              pprot_d;
  logic [NUM_PERIPH-1:0]   psel_d;
  logic                    penable_d, pwrite_d;
  logic [STRB_WIDTH-1:0]   pstrb_d;
  logic                    pready_sel, pslverr_sel;
  logic [IDX_WIDTH-1:0]    cmd_idx;

`ifdef APB4_REQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt, to_cnt_d;
`endif

  // Reject an out-of-range timeout at elaboration time
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb4_requester: TIMEOUT_CYCLES must be within 1..255");
  end

  assign cmd_idx     = cmd_addr[ADDR_WIDTH-1:4];
  assign pready_sel  = |(PREADY & PSEL);
  assign pslverr_sel = |(PSLVERR & PSEL);

  // AND-OR mux of the selected PRDATA slice; unselected slices are masked off
  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      rdata_sel = rdata_sel | (PRDATA[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{PSEL[k]}});
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d     = state;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    paddr_d     = PADDR;
    pprot_d     = PPROT;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    pstrb_d     = PSTRB;
`ifdef APB4_REQ_TIMEOUT_EN
    to_cnt_d    = to_cnt;
`endif
    case (state)
      IDLE: begin
        cmd_ready_d = 1'b1;
        psel_d      = '0;
        penable_d   = 1'b0;
        pstrb_d     = '0;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          if (cmd_idx < NUM_PERIPH_IDX) begin
            state_d  = SETUP;
            psel_d   = NUM_PERIPH'(1) << cmd_idx;
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pprot_d  = cmd_prot;
            pwdata_d = cmd_wdata;
            pstrb_d  = cmd_write ? cmd_strb : '0;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB4_REQ_TIMEOUT_EN
        to_cnt_d  = 8'd0;
`endif
      end
      ACCESS: begin
        if (pready_sel) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_sel;
          rsp_rdata_d = (!PWRITE && !pslverr_sel) ? rdata_sel : '0;
          psel_d      = '0;
          penable_d   = 1'b0;
          pstrb_d     = '0;
        end
`ifdef APB4_REQ_TIMEOUT_EN
        else if (to_cnt == TIMEOUT_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          psel_d      = '0;
          penable_d   = 1'b0;
          pstrb_d     = '0;
        end else begin
          to_cnt_d = to_cnt + 8'd1;
        end
`endif
      end
      RESP: begin
        cmd_ready_d = 1'b0;
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transfer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      PADDR     <= '0;
      PPROT     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
`ifdef APB4_REQ_TIMEOUT_EN
      to_cnt    <= 8'd0;
`endif
    end else begin
      state     <= state_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      PADDR     <= paddr_d;
      PPROT     <= pprot_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
`ifdef APB4_REQ_TIMEOUT_EN
      to_cnt    <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb4_requester.sv
// Testbench for apb4_requester: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
// The timeout scenarios run only when APB4_REQ_TIMEOUT_EN is defined.
module tb_apb4_requester;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int SW = DW / 8;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;
  logic [SW-1:0]    cmd_strb;
  logic [2:0]       cmd_prot;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]    rsp_rdata;
  logic [AW-1:0]    PADDR;
  logic [2:0]       PPROT;
  logic [NP-1:0]    PSEL;
  logic             PENABLE, PWRITE;
  logic [DW-1:0]    PWDATA;
  logic [SW-1:0]    PSTRB;
  logic [NP*DW-1:0] PRDATA;
  logic [NP-1:0]    PREADY, PSLVERR;

  int n_vectors = 0;
  int n_miscompares = 0;

  apb4_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PERIPH(NP), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vectors++;
    if (got !== expv) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic scrambleCompleters(input logic [NP-1:0] keep_mask);
    for (int k = 0; k < NP; k++) PRDATA[k*DW +: DW] = $urandom;
    PREADY  = NP'($urandom) & ~keep_mask;
    PSLVERR = NP'($urandom) & ~keep_mask;
  endtask

  // One complete command/response transaction with a completer model that
  // inserts 'waits' wait states and may flag an error
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                               input logic slverr, input logic [DW-1:0] rdval, input int hold);
    logic          dec_err, exp_err;
    int            idx, exp_lat, cyc, acc;
    logic [NP-1:0] exp_psel;
    logic [DW-1:0] exp_rdata;
    logic [SW-1:0] exp_pstrb;
    dec_err   = (addr >> 4) >= AW'(NP);
    idx       = dec_err ? 0 : int'(addr >> 4);
    exp_psel  = dec_err ? '0 : NP'(1 << idx);
    exp_lat   = dec_err ? 1 : 3 + waits;
    exp_err   = dec_err || slverr;
    exp_rdata = (!wr && !exp_err) ? rdval : '0;
    exp_pstrb = wr ? strb : '0;

    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot; rsp_ready = 1'b0;
    scrambleCompleters(exp_psel);
    if (!dec_err) PRDATA[idx*DW +: DW] = rdval;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge PCLK);
      cyc++;
    end
    checkOutput("cmd_ready_wait", cmd_ready, 1'b1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cyc = 1;
    if (!dec_err) begin
      checkOutput("setup_psel", PSEL, exp_psel);
      checkOutput("setup_penable", PENABLE, 1'b0);
      checkOutput("setup_paddr", PADDR, addr);
      checkOutput("setup_pwrite", PWRITE, wr);
      checkOutput("setup_pwdata", PWDATA, wdata);
      checkOutput("setup_pprot", PPROT, prot);
      checkOutput("setup_pstrb", PSTRB, exp_pstrb);
    end
    acc = 0;
    while (!rsp_valid && cyc < 60) begin
      if (PENABLE) begin
        checkOutput("access_psel", PSEL, exp_psel);
        checkOutput("access_paddr", PADDR, addr);
        checkOutput("access_pstrb", PSTRB, exp_pstrb);
        PREADY  = (NP'($urandom) & ~exp_psel) | ((acc == waits) ? exp_psel : '0);
        PSLVERR = (NP'($urandom) & ~exp_psel) |
                  ((acc == waits) ? (slverr ? exp_psel : '0) : (NP'($urandom) & exp_psel));
        acc++;
      end
      @(negedge PCLK);
      cyc++;
    end
    scrambleCompleters('0);
    checkOutput("rsp_latency", cyc, exp_lat);
    checkOutput("rsp_err", rsp_err, exp_err);
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("resp_psel", PSEL, '0);
    checkOutput("resp_penable", PENABLE, 1'b0);
    checkOutput("resp_pstrb", PSTRB, '0);
    checkOutput("resp_cmd_ready", cmd_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge PCLK);
      scrambleCompleters('0);
      checkOutput("hold_rsp_valid", rsp_valid, 1'b1);
      checkOutput("hold_rsp_err", rsp_err, exp_err);
      checkOutput("hold_rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checkOutput("post_rsp_valid", rsp_valid, 1'b0);
    checkOutput("post_cmd_ready", cmd_ready, 1'b1);
    checkOutput("post_pstrb", PSTRB, '0);
  endtask

  // Runaway guard in case the design stops responding altogether
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, directed scenarios, reset during ACCESS, random traffic
  initial begin
    int acc;
    logic [AW-1:0] a;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    PRDATA = '0; PREADY = '0; PSLVERR = '0;
    #12;
    checkOutput("reset_cmd_ready", cmd_ready, 1'b0);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_rdata", rsp_rdata, '0);
    checkOutput("reset_rsp_err", rsp_err, 1'b0);
    checkOutput("reset_psel", PSEL, '0);
    checkOutput("reset_penable", PENABLE, 1'b0);
    checkOutput("reset_paddr", PADDR, '0);
    checkOutput("reset_pstrb", PSTRB, '0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    checkOutput("release_cmd_ready", cmd_ready, 1'b1);

    applyStimulus(1'b1, 32'h14, 32'hA5A5_0001, 4'hF, 3'd2, 0, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 32'h18, 32'h1234_5678, 4'h5, 3'd1, 2, 1'b0, 32'h0000_00C3, 0);
    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 3'd0, 1, 1'b1, 32'hFFFF_FFFF, 4);

    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'hDEAD_BEEF;
    cmd_strb = 4'hF; cmd_prot = 3'd0; PREADY = '0; PSLVERR = '0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    checkOutput("rst_pre_penable", PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("rst_async_psel", PSEL, '0);
    checkOutput("rst_async_penable", PENABLE, 1'b0);
    checkOutput("rst_async_cmd_ready", cmd_ready, 1'b0);
    checkOutput("rst_async_rsp_valid", rsp_valid, 1'b0);
    PREADY = '1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    checkOutput("rst_after_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      checkOutput("rst_no_rsp", rsp_valid, 1'b0);
    end
    PREADY = '0;

`ifdef APB4_REQ_TIMEOUT_EN
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; PREADY = '0; PSLVERR = '0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    acc = 0;
    while (PENABLE && acc < 100) begin
      PREADY = NP'($urandom) & 4'b1011;
      acc++;
      @(negedge PCLK);
    end
    checkOutput("timeout_access_cycles", acc, 16);
    checkOutput("timeout_psel", PSEL, '0);
    checkOutput("timeout_rsp_valid", rsp_valid, 1'b1);
    checkOutput("timeout_rsp_err", rsp_err, 1'b1);
    checkOutput("timeout_rsp_rdata", rsp_rdata, '0);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checkOutput("timeout_post_rsp_valid", rsp_valid, 1'b0);
    applyStimulus(1'b0, 32'h2C, 32'h0, 4'h0, 3'd0, 15, 1'b0, 32'h5A5A_1234, 0);
`else
    acc = 0;
`endif

    for (int t = 0; t < 40; t++) begin
      a = {24'h0, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 7) == 0) a = $urandom;
      applyStimulus(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom),
                    $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom,
                    $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/apb4_requester.md
Name: apb4_requester

Overview:
- Upstream APB4 requester (bridge) that turns single-beat commands on a valid/ready request channel into APB4 SETUP/ACCESS transfers.
- Decodes the target into one of NUM_PERIPH completer selects; each completer owns a 16-byte window.
- Returns read data and error status on a valid/ready response channel.
- Drives the register-based APB4 peripherals of the subsystem; one transfer in flight at a time.

Parameters:
- ADDR_WIDTH, 32, APB and command address width (8/16/24/32).
- DATA_WIDTH, 32, APB and command data width (8/16/32).
- NUM_PERIPH, 4, number of completers; completer k decodes byte addresses 16*k .. 16*k+15.
- TIMEOUT_CYCLES, 16, ACCESS cycles without PREADY before abort (used only with the optional feature); legal range 1..255.

Ports:
- PCLK  in  1  clock, all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errored transfers.
- rsp_err  out  1  decode error, PSLVERR or timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PPROT  out  3  APB protection.
- PSEL  out  NUM_PERIPH  one-hot completer select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB strobes.
- PRDATA  in  NUM_PERIPH*DATA_WIDTH  completer k read data in slice k.
- PREADY  in  NUM_PERIPH  per-completer ready.
- PSLVERR  in  NUM_PERIPH  per-completer error.

Behaviour:
- Reset: asynchronous assertion forces IDLE immediately, mid-transfer included; any in-flight command is dropped and no response is produced. All outputs reset to 0: cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB. The timeout counter also resets to 0.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On acceptance, capture the command and compute idx = cmd_addr[ADDR_WIDTH-1:4].
  - If idx<NUM_PERIPH, go to SETUP. Otherwise go to RESP with rsp_err=1 and rsp_rdata=0; no APB activity occurs.
- SETUP (exactly 1 cycle):
  - PSEL[idx]=1, PENABLE=0, PADDR=cmd_addr, PWRITE, PPROT, PWDATA as captured.
  - PSTRB=cmd_strb for writes, all-zero for reads.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE=1. PADDR, PWRITE, PWDATA, PSTRB, PPROT and PSEL are held stable.
  - Sample only PREADY[idx], PSLVERR[idx] and PRDATA slice idx.
  - When PREADY[idx]=1: rsp_err=PSLVERR[idx]; rsp_rdata=PRDATA slice if read && !PSLVERR, else 0.
  - On that same edge, drop PSEL and PENABLE to 0 and go to RESP. Wait states are unbounded unless the optional feature is enabled.
- RESP:
  - rsp_valid=1, cmd_ready=0. rsp_rdata and rsp_err are held until rsp_ready.
  - On handshake, go to IDLE.
  - No back-to-back APB transfers: at least one IDLE cycle separates transfers.
- Latency: command accepted at edge N gives SETUP in cycle N+1 and ACCESS from N+2. With zero wait states, rsp_valid rises at N+3; each wait state adds 1.
- Idle bus: PADDR, PWRITE and PPROT keep their last values. PWDATA keeps its last value. PSTRB returns to 0.
- Ignored inputs: PREADY and PSLVERR of unselected completers are ignored. X on unselected PRDATA slices must not propagate.

Optional Feature:
- Macro APB4_REQ_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When the counter equals TIMEOUT_CYCLES-1 with PREADY[idx] still 0, the transfer aborts: PSEL and PENABLE drop, then RESP with rsp_err=1 and rsp_rdata=0.
  - If PREADY arrives on the same cycle as the timeout, the transfer completes normally and takes precedence over the abort.
- Disabled: no counter is built, and ACCESS waits indefinitely for PREADY.

Test Plan:
1. Write addr 0x14, wdata 0xA5A5_0001, strb 0xF, completer 1 zero-wait → PSEL=4'b0010, SETUP then ACCESS, PSTRB=0xF; rsp_valid 3 cycles after accept with rsp_err=0 and rsp_rdata=0.
2. Read addr 0x18, completer 1 inserts 2 wait states returning 0x0000_00C3 → PSTRB=0 and PADDR stable through 3 ACCESS cycles; rsp_valid 5 cycles after accept, rsp_rdata=0x0000_00C3, rsp_err=0.
3. Read addr 0x40 with NUM_PERIPH=4 → no PSEL asserted; rsp_valid 1 cycle after accept with rsp_err=1 and rsp_rdata=0.
4. Read addr 0x08, completer 0 returns PSLVERR=1 and PRDATA=0xFFFF_FFFF → rsp_err=1, rsp_rdata=0; hold rsp_ready=0 for 4 cycles → response stable and cmd_ready=0 throughout.
5. PRESETn pulsed low during ACCESS of a write to 0x24 → PSEL, PENABLE, cmd_ready and rsp_valid go to 0 asynchronously; after release cmd_ready=1 and no response is ever issued.
6. With APB4_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, completer 2 never asserts PREADY → after 16 ACCESS cycles PSEL and PENABLE drop, then rsp_err=1 and rsp_rdata=0.
